// File: rtl/alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver
//
// Purpose:
//   Sequences single commands into an external combinational ALU. A command
//   is accepted in IDLE, the ALU operands/opcode are registered and held, the
//   block waits SETTLE cycles for the ALU to settle, captures the ALU result
//   and flags into a response register, and presents that response until it
//   is consumed. A free-running 8-bit counter tracks completed responses.
//
// Parameters:
//   W       operand/result width of the attached ALU.
//   SETTLE  cycles the ALU inputs are held before capture (0..15).
//
// Build option:
//   ALU_DRV_CHAIN_EN  when defined, a chain register keeps the last captured
//                     result; a command with CMD_CHAIN=1 uses it as operand A.
//                     When undefined, CMD_CHAIN is ignored and operand A is
//                     always CMD_A.
//
// Ports:
//   CLK        in   1  clock, rising edge
//   RST        in   1  synchronous reset, active-high
//   CMD_VALID  in   1  command offered
//   CMD_READY  out  1  command accepted when high with CMD_VALID (IDLE only)
//   CMD_OP     in   2  opcode: 00 ADD, 01 AND, 10 NOT, 11 ZERO
//   CMD_A      in   W  operand A
//   CMD_B      in   W  operand B
//   CMD_CHAIN  in   1  take operand A from the last result (chain build only)
//   ALU_CTRL   out  2  ALU opcode select (registered)
//   ALU_IN1    out  W  ALU operand 1 (registered)
//   ALU_IN2    out  W  ALU operand 2 (registered)
//   ALU_OUT    in   W  ALU result
//   ALU_CF     in   1  ALU carry flag
//   ALU_Z      in   1  ALU zero flag
//   RSP_VALID  out  1  response valid
//   RSP_READY  in   1  response consumed when high with RSP_VALID
//   RSP_DATA   out  W  captured result
//   RSP_CF     out  1  captured carry flag
//   RSP_Z      out  1  captured zero flag
//   BUSY       out  1  high in any state other than IDLE
//   OPS_DONE   out  8  completed responses, wraps 255 -> 0
// -----------------------------------------------------------------------------
module alu_cmd_driver #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CMD_VALID,
  output logic         CMD_READY,
  input  logic [1:0]   CMD_OP,
  input  logic [W-1:0] CMD_A,
  input  logic [W-1:0] CMD_B,
  input  logic         CMD_CHAIN,
  output logic [1:0]   ALU_CTRL,
  output logic [W-1:0] ALU_IN1,
  output logic [W-1:0] ALU_IN2,
  input  logic [W-1:0] ALU_OUT,
  input  logic         ALU_CF,
  input  logic         ALU_Z,
  output logic         RSP_VALID,
  input  logic         RSP_READY,
  output logic [W-1:0] RSP_DATA,
  output logic         RSP_CF,
  output logic         RSP_Z,
  output logic         BUSY,
  output logic [7:0]   OPS_DONE
);

  // Wait counter is sized for the full 0..15 SETTLE range.
  localparam int         CNT_W      = 4;
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [1:0]         alu_ctrl_q,  alu_ctrl_d;
  logic [W-1:0]       alu_in1_q,   alu_in1_d;
  logic [W-1:0]       alu_in2_q,   alu_in2_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_data_q,  rsp_data_d;
  logic               rsp_cf_q,    rsp_cf_d;
  logic               rsp_z_q,     rsp_z_d;
  logic [7:0]         ops_done_q,  ops_done_d;

  // Operand A selection at accept time.
  logic [W-1:0]       operand_a;

`ifdef ALU_DRV_CHAIN_EN
  // Last captured result, reused as operand A for chained commands.
  logic [W-1:0]       chain_q,     chain_d;

  assign operand_a = CMD_CHAIN ? chain_q : CMD_A;
`else
  // CMD_CHAIN stays on the port list for a uniform interface but has no
  // effect in this build.
  logic               unused_cmd_chain;

  assign unused_cmd_chain = CMD_CHAIN;
  assign operand_a        = CMD_A;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_cf_d    = rsp_cf_q;
    rsp_z_d     = rsp_z_q;
    ops_done_d  = ops_done_q;
`ifdef ALU_DRV_CHAIN_EN
    chain_d     = chain_q;
`endif

    case (state_q)
      S_IDLE: begin
        // ALU inputs only change here, so they stay stable from one accept
        // edge to the next regardless of what CMD_* does meanwhile.
        if (CMD_VALID) begin
          alu_ctrl_d = CMD_OP;
          alu_in1_d  = operand_a;
          alu_in2_d  = CMD_B;
          cnt_d      = SETTLE_CNT;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // Capture happens on the edge where the counter already reads zero,
        // so the response rises SETTLE+1 edges after the accept edge.
        if (cnt_q == '0) begin
          rsp_data_d  = ALU_OUT;
          rsp_cf_d    = ALU_CF;
          rsp_z_d     = ALU_Z;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
`ifdef ALU_DRV_CHAIN_EN
          chain_d     = ALU_OUT;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RESP: begin
        // Response data is left in place after consume; only VALID drops.
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 8'd1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      // Any in-flight command is dropped: no response, no count.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_ctrl_q  <= 2'b00;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cf_q    <= 1'b0;
      rsp_z_q     <= 1'b0;
      ops_done_q  <= 8'd0;
`ifdef ALU_DRV_CHAIN_EN
      chain_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cf_q    <= rsp_cf_d;
      rsp_z_q     <= rsp_z_d;
      ops_done_q  <= ops_done_d;
`ifdef ALU_DRV_CHAIN_EN
      chain_q     <= chain_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign ALU_CTRL  = alu_ctrl_q;
  assign ALU_IN1   = alu_in1_q;
  assign ALU_IN2   = alu_in2_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_CF    = rsp_cf_q;
  assign RSP_Z     = rsp_z_q;
  assign OPS_DONE  = ops_done_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_driver
//
// Drives alu_cmd_driver (W=4, SETTLE=1) with a small behavioural ALU attached.
// Table-driven command vectors plus hand sequences for reset-in-WAIT,
// backpressure, chaining and OPS_DONE wrap. Outputs are sampled on the
// falling edge; inputs are changed on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_cmd_driver;

  localparam int W      = 4;
  localparam int SETTLE = 1;

  logic         CLK = 1'b0;
  logic         RST;
  logic         CMD_VALID;
  logic         CMD_READY;
  logic [1:0]   CMD_OP;
  logic [W-1:0] CMD_A;
  logic [W-1:0] CMD_B;
  logic         CMD_CHAIN;
  logic [1:0]   ALU_CTRL;
  logic [W-1:0] ALU_IN1;
  logic [W-1:0] ALU_IN2;
  logic [W-1:0] ALU_OUT;
  logic         ALU_CF;
  logic         ALU_Z;
  logic         RSP_VALID;
  logic         RSP_READY;
  logic [W-1:0] RSP_DATA;
  logic         RSP_CF;
  logic         RSP_Z;
  logic         BUSY;
  logic [7:0]   OPS_DONE;

  always #5 CLK = ~CLK;

  alu_cmd_driver #(.W(W), .SETTLE(SETTLE)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_A     (CMD_A),
    .CMD_B     (CMD_B),
    .CMD_CHAIN (CMD_CHAIN),
    .ALU_CTRL  (ALU_CTRL),
    .ALU_IN1   (ALU_IN1),
    .ALU_IN2   (ALU_IN2),
    .ALU_OUT   (ALU_OUT),
    .ALU_CF    (ALU_CF),
    .ALU_Z     (ALU_Z),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_DATA  (RSP_DATA),
    .RSP_CF    (RSP_CF),
    .RSP_Z     (RSP_Z),
    .BUSY      (BUSY),
    .OPS_DONE  (OPS_DONE)
  );

  // Behavioural ALU. The flip controls let the bench present flag values
  // that differ from the arithmetic, to prove they are passed through as-is.
  logic         cf_flip;
  logic         z_flip;
  logic [W:0]   alu_sum;
  logic [W-1:0] alu_res;
  logic         alu_c;

  assign alu_sum = {1'b0, ALU_IN1} + {1'b0, ALU_IN2};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (ALU_CTRL)
      2'b00:   begin alu_res = alu_sum[W-1:0]; alu_c = alu_sum[W]; end
      2'b01:   alu_res = ALU_IN1 & ALU_IN2;
      2'b10:   alu_res = ~ALU_IN1;
      default: alu_res = '0;
    endcase
  end

  assign ALU_OUT = alu_res;
  assign ALU_CF  = alu_c ^ cf_flip;
  assign ALU_Z   = (alu_res == '0) ^ z_flip;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] ops_exp  = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One full command: accept, wait for response, optional backpressure,
  // consume. Called at a falling edge with the DUT in IDLE.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic chain, input logic [3:0] exp_a1, input int hold,
                        input logic early, input logic [3:0] exp_data,
                        input logic exp_cf, input logic exp_z);
    int edges;
    check("cmd_ready_idle", CMD_READY, 1'b1);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_A     = a;
    CMD_B     = b;
    CMD_CHAIN = chain;
    step();
    // Scramble the command inputs: the registered ALU inputs must not follow.
    CMD_VALID = 1'b0;
    CMD_OP    = 2'($urandom_range(3, 0));
    CMD_A     = 4'($urandom_range(15, 0));
    CMD_B     = 4'($urandom_range(15, 0));
    CMD_CHAIN = 1'($urandom_range(1, 0));
    if (early) RSP_READY = 1'b1;
    check("busy_wait", BUSY, 1'b1);
    check("cmd_ready_wait", CMD_READY, 1'b0);
    check("alu_in1", ALU_IN1, exp_a1);
    check("alu_in2", ALU_IN2, b);
    edges = 0;
    while (!RSP_VALID && edges < 20) begin
      check("alu_ctrl_hold", ALU_CTRL, op);
      step();
      edges++;
    end
    check("rsp_latency", edges, SETTLE + 1);
    check("rsp_data", RSP_DATA, exp_data);
    check("rsp_cf", RSP_CF, exp_cf);
    check("rsp_z", RSP_Z, exp_z);
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", RSP_VALID, 1'b1);
      check("hold_data", RSP_DATA, exp_data);
      check("hold_busy", BUSY, 1'b1);
    end
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;
    ops_exp   = ops_exp + 8'd1;
    check("consume_valid", RSP_VALID, 1'b0);
    check("ops_done", OPS_DONE, ops_exp);
    check("data_retained", RSP_DATA, exp_data);
    check("cmd_ready_after", CMD_READY, 1'b1);
    $display("TXN op=%0d a=%0h b=%0h chain=%0b data=%0h cf=%0b z=%0b ops=%0d",
             op, a, b, chain, RSP_DATA, RSP_CF, RSP_Z, OPS_DONE);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         hold;
    logic       early;
    logic [3:0] exp_data;
    logic       exp_cf;
    logic       exp_z;
  } vec_t;

  vec_t vecs [8];

`ifdef ALU_DRV_CHAIN_EN
  localparam logic [3:0] CHAIN_A1   = 4'h7;
  localparam logic [3:0] CHAIN_DATA = 4'h9;
`else
  localparam logic [3:0] CHAIN_A1   = 4'h0;
  localparam logic [3:0] CHAIN_DATA = 4'h2;
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ra, rb;

    //            op     a     b     hold early data   cf    z
    vecs[0] = '{2'b00, 4'h9, 4'h8, 0, 1'b0, 4'h1, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 4'hC, 4'h3, 1, 1'b0, 4'h0, 1'b0, 1'b1};
    vecs[2] = '{2'b10, 4'hA, 4'h5, 0, 1'b0, 4'h5, 1'b0, 1'b0};
    vecs[3] = '{2'b00, 4'hF, 4'h1, 0, 1'b1, 4'h0, 1'b1, 1'b1};
    vecs[4] = '{2'b00, 4'h2, 4'h3, 2, 1'b0, 4'h5, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 4'h7, 4'h7, 0, 1'b0, 4'h0, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 4'hF, 4'h6, 0, 1'b1, 4'h6, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 4'h0, 4'hF, 1, 1'b0, 4'hF, 1'b0, 1'b0};

    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_A = '0; CMD_B = '0;
    CMD_CHAIN = 1'b0; RSP_READY = 1'b0; cf_flip = 1'b0; z_flip = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Reset state; CMD_READY already high in the first cycle after reset.
    check("rst_cmd_ready", CMD_READY, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_rsp_valid", RSP_VALID, 1'b0);
    check("rst_rsp_data", RSP_DATA, 4'h0);
    check("rst_rsp_flags", {RSP_CF, RSP_Z}, 2'b00);
    check("rst_alu_ctrl", ALU_CTRL, 2'b00);
    check("rst_alu_in", {ALU_IN1, ALU_IN2}, 8'h00);
    check("rst_ops_done", OPS_DONE, 8'd0);

    // Reset during WAIT drops the command.
    CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_A = 4'h6; CMD_B = 4'h7;
    step();
    CMD_VALID = 1'b0;
    check("rw_busy", BUSY, 1'b1);
    check("rw_alu_in1", ALU_IN1, 4'h6);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rw_cmd_ready", CMD_READY, 1'b1);
    check("rw_alu_in", {ALU_IN1, ALU_IN2}, 8'h00);
    check("rw_ops_done", OPS_DONE, 8'd0);
    for (int i = 0; i < 4; i++) begin
      check("rw_no_valid", RSP_VALID, 1'b0);
      check("rw_ops_still", OPS_DONE, 8'd0);
      step();
    end
    $display("TXN reset-in-wait ops=%0d", OPS_DONE);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].a, vecs[i].hold,
             vecs[i].early, vecs[i].exp_data, vecs[i].exp_cf, vecs[i].exp_z);
    end

    // Backpressure with a second command held on CMD_VALID throughout.
    CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_A = 4'h5; CMD_B = 4'h6; CMD_CHAIN = 1'b0;
    step();
    CMD_OP = 2'b10; CMD_A = 4'hF; CMD_B = 4'h3;
    check("bp_alu_in1", ALU_IN1, 4'h5);
    step();
    check("bp_not_yet", RSP_VALID, 1'b0);
    check("bp_ready_wait", CMD_READY, 1'b0);
    step();
    check("bp_valid", RSP_VALID, 1'b1);
    check("bp_data", RSP_DATA, 4'hB);
    check("bp_flags", {RSP_CF, RSP_Z}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", RSP_VALID, 1'b1);
      check("bp_hold_data", RSP_DATA, 4'hB);
      check("bp_hold_cmd_ready", CMD_READY, 1'b0);
      check("bp_hold_busy", BUSY, 1'b1);
      check("bp_hold_alu", {ALU_CTRL, ALU_IN1, ALU_IN2}, {2'b00, 4'h5, 4'h6});
    end
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;
    ops_exp = ops_exp + 8'd1;
    check("bp_consumed", RSP_VALID, 1'b0);
    check("bp_ops", OPS_DONE, ops_exp);
    check("bp_idle_ready", CMD_READY, 1'b1);
    check("bp_not_accepted", ALU_CTRL, 2'b00);
    $display("TXN backpressure first data=%0h ops=%0d", RSP_DATA, OPS_DONE);
    step();
    CMD_VALID = 1'b0;
    check("bp2_accepted", {ALU_CTRL, ALU_IN1, ALU_IN2}, {2'b10, 4'hF, 4'h3});
    check("bp2_busy", BUSY, 1'b1);
    step();
    step();
    check("bp2_valid", RSP_VALID, 1'b1);
    check("bp2_data", RSP_DATA, 4'h0);
    check("bp2_flags", {RSP_CF, RSP_Z}, 2'b01);
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;
    ops_exp = ops_exp + 8'd1;
    check("bp2_ops", OPS_DONE, ops_exp);
    $display("TXN backpressure second data=%0h ops=%0d", RSP_DATA, OPS_DONE);

    // Chaining: 3+4, then (chain or 0)+2.
    do_cmd(2'b00, 4'h3, 4'h4, 1'b0, 4'h3, 0, 1'b0, 4'h7, 1'b0, 1'b0);
    do_cmd(2'b00, 4'h0, 4'h2, 1'b1, CHAIN_A1, 0, 1'b0, CHAIN_DATA, 1'b0, 1'b0);

    // OPS_DONE wrap over 256 ZERO commands, flags passed through verbatim.
    RST = 1'b1;
    step();
    RST = 1'b0;
    ops_exp = 8'd0;
    check("wrap_start", OPS_DONE, 8'd0);
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      z_flip  = i[0];
      cf_flip = i[1];
      do_cmd(2'b11, ra, rb, 1'b0, ra, 0, 1'b0, 4'h0, i[1], ~i[0]);
      if (i == 254) check("wrap_255", OPS_DONE, 8'd255);
    end
    z_flip  = 1'b0;
    cf_flip = 1'b0;
    check("wrap_zero", OPS_DONE, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
